// File: rtl/light_sequencer.sv
// light_sequencer: front-end controller for the lights selector (white / manual RGB / auto RGB).
// Latency: raw press -> state/sel/button change DEBOUNCE_CYCLES+2 edges after the raw edge is sampled.
// No backpressure: button is a fire-and-forget one-cycle pulse, never asserted two cycles in a row.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (0 = reset)
//   btn_raw   raw colour-step button (asynchronous, may bounce)
//   mode_raw  raw mode button (asynchronous, may bounce)
//   auto_en   synchronous level, selects auto cycling while in RGB
//   sel       0 = white light, 1 = RGB colour (registered)
//   button    one-cycle colour-step pulse to the lighting counter (registered)
//   state     00 WHITE, 01 MANUAL, 10 AUTO
module light_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_PERIOD     = 16,
  parameter int IDLE_TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       mode_raw,
  input  logic       auto_en,
  output logic       sel,
  output logic       button,
  output logic [1:0] state
);

  localparam logic [1:0] ST_WHITE  = 2'b00;
  localparam logic [1:0] ST_MANUAL = 2'b01;
  localparam logic [1:0] ST_AUTO   = 2'b10;

  // +1 keeps the debounce counter at least one bit wide when DEBOUNCE_CYCLES is 1.
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT);
  localparam int SW = $clog2(STEP_PERIOD);

  // Index 0 = colour-step button, index 1 = mode button.
  logic [1:0] raw_vec;
  logic [1:0] press_w;

  assign raw_vec = {mode_raw, btn_raw};

  for (genvar i = 0; i < 2; i++) begin : g_db
    logic          sync1_q, sync2_q;
    logic          acc_q, acc_d;
    logic          press_q, press_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Counter only advances while the synchronised level disagrees with the
    // accepted one; any agreeing cycle throws the partial count away.
    always_comb begin
      cnt_d   = '0;
      acc_d   = acc_q;
      press_d = 1'b0;
      if (sync2_q != acc_q) begin
        if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          acc_d   = sync2_q;
          press_d = sync2_q;  // only a 0->1 acceptance is a press
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        acc_q   <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_vec[i];
        sync2_q <= sync1_q;
        acc_q   <= acc_d;
        press_q <= press_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press_w[i] = press_q;
  end

  logic btn_press, mode_press;
  assign btn_press  = press_w[0];
  assign mode_press = press_w[1];

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [SW-1:0] step_q, step_d;
  logic          button_q, button_d;
  logic          sel_q, sel_d;

  // Counters default to zero so they sit at 0 outside their own state and
  // restart from 0 on every entry, press or expiry.
  always_comb begin
    state_d  = state_q;
    idle_d   = '0;
    step_d   = '0;
    button_d = 1'b0;
    case (state_q)
      ST_WHITE: begin
        if (mode_press) state_d = auto_en ? ST_AUTO : ST_MANUAL;
      end
      ST_MANUAL: begin
        if (mode_press)     state_d  = ST_WHITE;
        else if (auto_en)   state_d  = ST_AUTO;
        else if (btn_press) button_d = 1'b1;
        // Idle time is counted in clock cycles so the fall-back to WHITE
        // lands exactly IDLE_TIMEOUT edges after entry or the last press.
        else if (idle_q == IW'(IDLE_TIMEOUT - 1)) state_d = ST_WHITE;
        else                idle_d = idle_q + 1'b1;
      end
      ST_AUTO: begin
        if (mode_press)    state_d = ST_WHITE;
        else if (!auto_en) state_d = ST_MANUAL;
        // A press coinciding with expiry yields one pulse; a press right after
        // an expiry pulse is swallowed but still restarts the period.
        else if (btn_press || step_q == SW'(STEP_PERIOD - 1)) button_d = ~button_q;
        else               step_d = step_q + 1'b1;
      end
      default: state_d = ST_WHITE;
    endcase
    sel_d = (state_d != ST_WHITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_WHITE;
      idle_q   <= '0;
      step_q   <= '0;
      button_q <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      step_q   <= step_d;
      button_q <= button_d;
      sel_q    <= sel_d;
    end
  end

  assign state  = state_q;
  assign sel    = sel_q;
  assign button = button_q;

endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer: directed stimulus for light_sequencer with a timestamp-based reference model.
// Latency: model updates on each rising edge; DUT outputs are compared on every falling edge.
// No backpressure involved; inputs are driven on falling edges only.
module tb_light_sequencer;

  localparam int DEB  = 4;
  localparam int STEP = 16;
  localparam int IDLE = 64;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       mode_raw;
  logic       auto_en;
  logic       sel;
  logic       button;
  logic [1:0] state;

  light_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_PERIOD    (STEP),
    .IDLE_TIMEOUT   (IDLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .mode_raw(mode_raw),
    .auto_en (auto_en),
    .sel     (sel),
    .button  (button),
    .state   (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce: the level flips when the last DEB synchronised samples all differ
  // from the accepted level. The synchroniser delays the raw sample by two
  // edges, so at edge k the window is raw samples k-2 .. k-1-DEB.
  // Mode behaviour is expressed with edge timestamps instead of counters.
  logic [15:0] m_bh, m_mh;
  bit          m_bacc, m_macc, m_btn_pend, m_mode_pend;
  logic [1:0]  m_state;
  bit          m_button;
  int          mk, anchor;

  function automatic bit flips(input logic [15:0] h, input bit acc);
    for (int i = 1; i <= DEB; i++) begin
      if (h[i] == acc) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_bh = '0; m_mh = '0;
    m_bacc = 0; m_macc = 0; m_btn_pend = 0; m_mode_pend = 0;
    m_state = 2'd0; m_button = 0; mk = 0; anchor = 0;
  endtask

  task automatic model_step();
    bit mp, bp, ae, nb;
    mk++;
    mp = m_mode_pend;
    bp = m_btn_pend;
    ae = auto_en;
    nb = 0;
    case (m_state)
      2'd0: begin
        if (mp) begin m_state = ae ? 2'd2 : 2'd1; anchor = mk; end
      end
      2'd1: begin
        if (mp) m_state = 2'd0;
        else if (ae) begin m_state = 2'd2; anchor = mk; end
        else if (bp) begin nb = 1; anchor = mk; end
        else if (mk - anchor == IDLE) m_state = 2'd0;
      end
      default: begin
        if (mp) m_state = 2'd0;
        else if (!ae) begin m_state = 2'd1; anchor = mk; end
        else if (bp || (mk - anchor == STEP)) begin nb = !m_button; anchor = mk; end
      end
    endcase
    m_button = nb;

    m_btn_pend = 0;
    if (flips(m_bh, m_bacc)) begin m_bacc = !m_bacc; m_btn_pend = m_bacc; end
    m_mode_pend = 0;
    if (flips(m_mh, m_macc)) begin m_macc = !m_macc; m_mode_pend = m_macc; end
    m_bh = {m_bh[14:0], btn_raw};
    m_mh = {m_mh[14:0], mode_raw};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_button = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_state",  state,  m_state);
        check("model_sel",    {1'b0, sel},    {1'b0, m_state != 2'd0});
        check("model_button", {1'b0, button}, {1'b0, m_button});
        check("no_double_pulse", {1'b0, prev_button & button}, 2'd0);
        prev_button = button;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; btn_raw = 1'b0; mode_raw = 1'b0; auto_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk_en = 1;
    @(negedge clk);
    check("reset_state",  state, 2'd0);
    check("reset_sel",    {1'b0, sel}, 2'd0);
    check("reset_button", {1'b0, button}, 2'd0);
    cyc(2);
    rst = 1'b1;
    cyc(3);

    // mode press with auto_en=0 -> MANUAL after edge 6
    mode_raw = 1'b1;
    cyc(6); check("manual_not_yet", state, 2'd0);
    cyc(1); check("manual_state", state, 2'd1);
            check("manual_sel", {1'b0, sel}, 2'd1);
    cyc(3); mode_raw = 1'b0;
    cyc(10);

    // colour-step press: one pulse, 6 edges after raw rise
    btn_raw = 1'b1;
    cyc(6); check("press_pre",   {1'b0, button}, 2'd0);
    cyc(1); check("press_pulse", {1'b0, button}, 2'd1);
    cyc(1); check("press_post",  {1'b0, button}, 2'd0);
    cyc(2); btn_raw = 1'b0;
    cyc(10);

    // 3-cycle glitch is rejected (model compare covers every cycle)
    btn_raw = 1'b1;
    cyc(3); btn_raw = 1'b0;
    cyc(10);

    // second press lands 60 cycles after the first, restarting the idle count
    cyc(27); btn_raw = 1'b1;
    cyc(6); check("idle_press_pre", {1'b0, button}, 2'd0);
    cyc(1); check("idle_press",     {1'b0, button}, 2'd1);
    cyc(3); btn_raw = 1'b0;
    cyc(1); check("idle_restarted", state, 2'd1);
    cyc(59); check("idle_63", state, 2'd1);
    cyc(1);  check("idle_64_state", state, 2'd0);
             check("idle_64_sel",   {1'b0, sel}, 2'd0);

    // back to MANUAL, then auto_en -> AUTO on the next edge
    mode_raw = 1'b1;
    cyc(7); check("manual_again", state, 2'd1);
    cyc(3); mode_raw = 1'b0;
    cyc(10);
    auto_en = 1'b1;
    cyc(1);  check("auto_state", state, 2'd2);
             check("auto_sel",   {1'b0, sel}, 2'd1);
    cyc(15); check("auto_15", {1'b0, button}, 2'd0);
    cyc(1);  check("auto_16", {1'b0, button}, 2'd1);
    cyc(9);  btn_raw = 1'b1;               // press becomes effective at +32
    cyc(6);  check("auto_31", {1'b0, button}, 2'd0);
    cyc(1);  check("auto_32", {1'b0, button}, 2'd1);
    cyc(1);  check("auto_33", {1'b0, button}, 2'd0);
    cyc(2);  btn_raw = 1'b0;
    cyc(12); check("auto_47", {1'b0, button}, 2'd0);
    cyc(1);  check("auto_48", {1'b0, button}, 2'd1);

    // mode press and auto_en fall in the same cycle -> WHITE, no pulse
    mode_raw = 1'b1;
    cyc(6); check("combo_pre", state, 2'd2);
            auto_en = 1'b0;
    cyc(1); check("combo_state",  state, 2'd0);
            check("combo_sel",    {1'b0, sel}, 2'd0);
            check("combo_button", {1'b0, button}, 2'd0);
    cyc(3); mode_raw = 1'b0;
    cyc(10);

    // AUTO from WHITE, then async reset during a pulse
    auto_en = 1'b1; mode_raw = 1'b1;
    cyc(7);  check("auto2_state", state, 2'd2);
    cyc(3);  mode_raw = 1'b0;
    cyc(12); check("auto2_15", {1'b0, button}, 2'd0);
    cyc(1);  check("auto2_16", {1'b0, button}, 2'd1);
    rst = 1'b0;
    #1;
    check("rst_button", {1'b0, button}, 2'd0);
    check("rst_sel",    {1'b0, sel}, 2'd0);
    check("rst_state",  state, 2'd0);
    cyc(3);
    rst = 1'b1;
    cyc(40);
    check("post_rst_state",  state, 2'd0);
    check("post_rst_button", {1'b0, button}, 2'd0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
